// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// LS-first with a starvation limit for IF; one transaction outstanding at a time.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_if_req,
    input  logic [AW-1:0]     i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvld,
    output logic [DW-1:0]     o_if_rdata,
    input  logic              i_ls_req,
    input  logic [AW-1:0]     i_ls_addr,
    input  logic              i_ls_wen,
    input  logic [DW-1:0]     i_ls_wdata,
    input  logic [DW/8-1:0]   i_ls_bmask,
    output logic              o_ls_gnt,
    output logic              o_ls_rvld,
    output logic [DW-1:0]     o_ls_rdata,
    output logic              o_mem_vld,
    input  logic              i_mem_rdy,
    output logic [AW-1:0]     o_mem_addr,
    output logic              o_mem_wen,
    output logic [DW-1:0]     o_mem_wdata,
    output logic [DW/8-1:0]   o_mem_bmask,
    input  logic              i_mem_rvld,
    input  logic [DW-1:0]     i_mem_rdata,
    output logic              o_busy
);

    localparam int BW = DW / 8;
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [BW-1:0] bmask;
    } mem_req_t;

    state_t        state, state_nxt;
    mem_req_t      req_q, req_nxt;
    logic          owner_if, owner_nxt;
    logic          drop_q, drop_nxt;
    logic [CW-1:0] starve_cnt, starve_nxt;
    logic          if_rvld_q, ls_rvld_q;
    logic [DW-1:0] if_rdata_q, ls_rdata_q;
    logic          if_elig, ls_elig;
    logic          grant_if, grant_ls;
    logic          resp_take, resp_drop;

    always_comb begin
        state_nxt  = state;
        req_nxt    = req_q;
        owner_nxt  = owner_if;
        drop_nxt   = drop_q;
        starve_nxt = starve_cnt;
        grant_if   = 1'b0;
        grant_ls   = 1'b0;
        resp_take  = 1'b0;
        if_elig    = i_if_req & ~i_flush;
        ls_elig    = i_ls_req;

        case (state)
            IDLE: begin
                drop_nxt = 1'b0;
                if (!i_reset) begin
                    if (if_elig && (!ls_elig || starve_cnt == STARVE_LIM))
                        grant_if = 1'b1;
                    else if (ls_elig)
                        grant_ls = 1'b1;
                end
                if (grant_if) begin
                    req_nxt.addr  = i_if_addr;
                    req_nxt.wen   = 1'b0;
                    req_nxt.wdata = '0;
                    req_nxt.bmask = '1;
                    owner_nxt     = 1'b1;
                    starve_nxt    = '0;
                    state_nxt     = ISSUE;
                end else if (grant_ls) begin
                    req_nxt.addr  = i_ls_addr;
                    req_nxt.wen   = i_ls_wen;
                    req_nxt.wdata = i_ls_wdata;
                    req_nxt.bmask = i_ls_bmask;
                    owner_nxt     = 1'b0;
                    // Only an LS win against a waiting IF counts as an IF loss
                    if (i_if_req && starve_cnt != STARVE_LIM)
                        starve_nxt = starve_cnt + CW'(1);
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                if (owner_if && i_flush)
                    drop_nxt = 1'b1;
                if (i_mem_rdy)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (owner_if && i_flush)
                    drop_nxt = 1'b1;
                if (i_mem_rvld) begin
                    resp_take = 1'b1;
                    drop_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A flush landing on the response cycle itself still kills the fetch
        resp_drop = owner_if & (drop_q | i_flush);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            req_q      <= '0;
            owner_if   <= 1'b1;
            drop_q     <= 1'b0;
            starve_cnt <= '0;
            if_rvld_q  <= 1'b0;
            ls_rvld_q  <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state      <= state_nxt;
            req_q      <= req_nxt;
            owner_if   <= owner_nxt;
            drop_q     <= drop_nxt;
            starve_cnt <= starve_nxt;
            if_rvld_q  <= resp_take & owner_if & ~resp_drop;
            ls_rvld_q  <= resp_take & ~owner_if;
            if (resp_take && owner_if && !resp_drop)
                if_rdata_q <= i_mem_rdata;
            if (resp_take && !owner_if)
                ls_rdata_q <= i_mem_rdata;
        end
    end

    assign o_if_gnt    = grant_if;
    assign o_ls_gnt    = grant_ls;
    assign o_if_rvld   = if_rvld_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_ls_rvld   = ls_rvld_q;
    assign o_ls_rdata  = ls_rdata_q;
    assign o_mem_vld   = (state == ISSUE);
    assign o_mem_addr  = req_q.addr;
    assign o_mem_wen   = req_q.wen;
    assign o_mem_wdata = req_q.wdata;
    assign o_mem_bmask = req_q.bmask;
    assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random IF/LS/flush/bus traffic against a transaction-level model: arbitration
// rule, single outstanding request, memory contents and response routing.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          i_reset, i_flush;
    logic          i_if_req;
    logic [AW-1:0] i_if_addr;
    logic          o_if_gnt, o_if_rvld;
    logic [DW-1:0] o_if_rdata;
    logic          i_ls_req, i_ls_wen;
    logic [AW-1:0] i_ls_addr;
    logic [DW-1:0] i_ls_wdata;
    logic [BW-1:0] i_ls_bmask;
    logic          o_ls_gnt, o_ls_rvld;
    logic [DW-1:0] o_ls_rdata;
    logic          o_mem_vld, i_mem_rdy, o_mem_wen;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [BW-1:0] o_mem_bmask;
    logic          i_mem_rvld;
    logic [DW-1:0] i_mem_rdata;
    logic          o_busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_gnt(o_if_gnt), .o_if_rvld(o_if_rvld), .o_if_rdata(o_if_rdata),
        .i_ls_req(i_ls_req), .i_ls_addr(i_ls_addr), .i_ls_wen(i_ls_wen),
        .i_ls_wdata(i_ls_wdata), .i_ls_bmask(i_ls_bmask),
        .o_ls_gnt(o_ls_gnt), .o_ls_rvld(o_ls_rvld), .o_ls_rdata(o_ls_rdata),
        .o_mem_vld(o_mem_vld), .i_mem_rdy(i_mem_rdy), .o_mem_addr(o_mem_addr),
        .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
        .i_mem_rvld(i_mem_rvld), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference memory (fed by requests) and bus-side memory (fed by o_mem_*)
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bus_mem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction
    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = m[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction
    function automatic logic [31:0] rand_addr();
        return 32'h1000_0000 + ($urandom_range(0, 7) << 2);
    endfunction

    // model state
    bit          out_pend, acc, own_if, drop, rec_wen;
    logic [31:0] rec_addr, rec_wdata, exp_data, exp_rv_data, resp_data;
    logic [3:0]  rec_bmask;
    int          starve, resp_wait, mode;
    bit          resp_armed, exp_if_rv, exp_ls_rv, exp_ls_dchk;
    bit          if_gnt_seen, ls_gnt_seen;

    task automatic model_reset();
        out_pend = 0; acc = 0; drop = 0; starve = 0;
        resp_armed = 0; exp_if_rv = 0; exp_ls_rv = 0; exp_ls_dchk = 0;
        if_gnt_seen = 0; ls_gnt_seen = 0;
    endtask

    task automatic drive();
        bit holding;
        @(posedge clk); #1;
        holding = i_if_req && !if_gnt_seen;
        if (holding) begin
            if (mode == 0 && $urandom_range(0, 19) == 0) i_if_req = 1'b0;
        end else begin
            i_if_req = 1'b0;
            if (mode == 1 || $urandom_range(0, 2) == 0) begin
                i_if_req  = 1'b1;
                i_if_addr = rand_addr();
            end
        end
        holding = i_ls_req && !ls_gnt_seen;
        if (holding) begin
            if (mode == 0 && $urandom_range(0, 19) == 0) i_ls_req = 1'b0;
        end else begin
            i_ls_req = 1'b0;
            if (mode == 1 || $urandom_range(0, 2) == 0) begin
                i_ls_req   = 1'b1;
                i_ls_addr  = rand_addr();
                i_ls_wen   = 1'($urandom_range(0, 1));
                i_ls_wdata = $urandom;
                i_ls_bmask = 4'($urandom_range(0, 15));
            end
        end
        i_flush    = (mode == 0) && ($urandom_range(0, 7) == 0);
        i_mem_rdy  = ($urandom_range(0, 3) != 0);
        i_mem_rvld = 1'b0;
        i_mem_rdata = $urandom;
        if (resp_armed) begin
            if (resp_wait == 0) begin
                i_mem_rvld  = 1'b1;
                i_mem_rdata = resp_data;
                resp_armed  = 0;
            end else begin
                resp_wait--;
            end
        end
    endtask

    task automatic check_cycle();
        bit busy0, exp_vld, if_el, ls_el, e_if, e_ls;
        @(negedge clk);
        busy0 = out_pend;
        chk("if_rvld", o_if_rvld, exp_if_rv);
        chk("ls_rvld", o_ls_rvld, exp_ls_rv);
        if (exp_if_rv) chk("if_rdata", o_if_rdata, exp_rv_data);
        if (exp_ls_rv && exp_ls_dchk) chk("ls_rdata", o_ls_rdata, exp_rv_data);
        exp_if_rv = 0; exp_ls_rv = 0; exp_ls_dchk = 0;
        chk("gnt_excl", o_if_gnt & o_ls_gnt, 0);
        chk("busy", o_busy, busy0);

        exp_vld = busy0 && !acc;
        chk("mem_vld", o_mem_vld, exp_vld);
        if (exp_vld && o_mem_vld) begin
            chk("mem_addr", o_mem_addr, rec_addr);
            chk("mem_wen", o_mem_wen, rec_wen);
            chk("mem_bmask", o_mem_bmask, rec_bmask);
            if (rec_wen) chk("mem_wdata", o_mem_wdata, rec_wdata);
            if (i_mem_rdy) begin
                acc = 1;
                if (o_mem_wen) begin
                    bus_mem[o_mem_addr] = merge(bus_rd(o_mem_addr), o_mem_wdata, o_mem_bmask);
                    resp_data = $urandom;
                end else begin
                    resp_data = bus_rd(o_mem_addr);
                end
                resp_armed = 1;
                resp_wait  = $urandom_range(0, 3);
            end
        end
        if (busy0 && own_if && i_flush) drop = 1;
        if (busy0 && i_mem_rvld) begin
            if (own_if) exp_if_rv = !drop;
            else begin
                exp_ls_rv   = 1;
                exp_ls_dchk = !rec_wen;
            end
            exp_rv_data = exp_data;
            out_pend = 0;
            acc = 0;
        end

        if_el = i_if_req && !i_flush;
        ls_el = i_ls_req;
        e_if = 0; e_ls = 0;
        if (!busy0) begin
            if (if_el && (!ls_el || starve == SMAX)) e_if = 1;
            else if (ls_el) e_ls = 1;
        end
        chk("if_gnt", o_if_gnt, e_if);
        chk("ls_gnt", o_ls_gnt, e_ls);
        if (e_if) begin
            out_pend = 1; own_if = 1; drop = 0;
            rec_addr = i_if_addr; rec_wen = 0; rec_bmask = 4'hF; rec_wdata = '0;
            exp_data = ref_rd(i_if_addr);
            starve = 0;
        end else if (e_ls) begin
            out_pend = 1; own_if = 0; drop = 0;
            rec_addr = i_ls_addr; rec_wen = i_ls_wen;
            rec_bmask = i_ls_bmask; rec_wdata = i_ls_wdata;
            if (i_ls_wen) ref_mem[i_ls_addr] = merge(ref_rd(i_ls_addr), i_ls_wdata, i_ls_bmask);
            else exp_data = ref_rd(i_ls_addr);
            if (i_if_req && starve < SMAX) starve++;
        end
        if_gnt_seen = o_if_gnt;
        ls_gnt_seen = o_ls_gnt;
    endtask

    task automatic step();
        drive();
        check_cycle();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        i_reset = 1'b1; i_flush = 1'b0; i_if_req = 1'b0; i_ls_req = 1'b0;
        i_mem_rvld = 1'b0; i_mem_rdy = 1'b0;
        @(negedge clk);
        chk("rst_gnt", {o_if_gnt, o_ls_gnt}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ctl", {o_if_gnt, o_if_rvld, o_ls_gnt, o_ls_rvld, o_mem_vld,
                        o_mem_wen, o_busy, o_mem_bmask}, 0);
        chk("rst_if_rdata", o_if_rdata, 0);
        chk("rst_ls_rdata", o_ls_rdata, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
        chk("rst_mem_wdata", o_mem_wdata, 0);
        model_reset();
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int guard;
        i_reset = 1'b1; i_flush = 1'b0; i_if_req = 1'b0; i_if_addr = '0;
        i_ls_req = 1'b0; i_ls_addr = '0; i_ls_wen = 1'b0; i_ls_wdata = '0;
        i_ls_bmask = '0; i_mem_rdy = 1'b0; i_mem_rvld = 1'b0; i_mem_rdata = '0;
        mode = 0;
        model_reset();
        do_reset();

        repeat (3000) step();
        mode = 1;
        repeat (400) step();
        mode = 0;
        repeat (1000) step();

        // reset while waiting for a response, then a stray response strobe
        guard = 0;
        while (!(out_pend && acc) && guard < 200) begin
            step();
            guard++;
        end
        chk("reach_wait", out_pend && acc, 1);
        resp_armed = 0;
        do_reset();
        @(posedge clk); #1;
        i_mem_rvld = 1'b1; i_mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("stray_busy", o_busy, 0);
        @(posedge clk); #1;
        i_mem_rvld = 1'b0;
        @(negedge clk);
        chk("stray_rvld", {o_if_rvld, o_ls_rvld}, 0);

        repeat (500) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
